// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined
// carry-lookahead adder.
package adder_pkg;

   // Flags that leave the final stage alongside the sum
   typedef struct packed {
      logic cout;
      logic ovf;
   } beat_flags_t;

   // Number of lookahead groups, one per pipeline stage
   function automatic int calc_ng(input int width, input int block);
      return width / block;
   endfunction

   // Width must split into whole, non-empty groups
   function automatic bit split_ok(input int width, input int block);
      return (block > 0) && (width >= block) && (width % block == 0);
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// Combinational BLOCK-bit carry-lookahead group.
// Each carry is a flat sum of generate/propagate products.
module cla_group #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [BLOCK-1:0] w_p;
   logic [BLOCK-1:0] w_g;
   logic [BLOCK:0]   w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Expand every carry as g_i | p_i g_i-1 | ... | p_i..p_0 ci
   always_comb begin
      logic v_t;
      logic v_pp;
      v_t    = 1'b0;
      v_pp   = 1'b0;
      w_c    = '0;
      w_c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         v_t  = w_g[i];
         v_pp = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            v_t  = v_t | (v_pp & w_g[j]);
            v_pp = v_pp & w_p[j];
         end
         w_c[i+1] = v_t | (v_pp & ci);
      end
   end

   assign s     = w_p ^ w_c[BLOCK-1:0];
   assign co    = w_c[BLOCK];
   assign c_msb = w_c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit
// group resolved per stage, global stall on output backpressure.
module pipelined_cla_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NG = calc_ng(WIDTH, BLOCK);

   if (!split_ok(WIDTH, BLOCK)) begin : g_bad_split
      $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;

   // Subtract is a + ~b + ~borrow
   assign w_adv   = !out_valid || out_ready;
   assign in_ready = w_adv;
   assign w_b_eff = sub ? ~b : b;
   assign w_c0    = cin ^ sub;

   // Stage k consumes the lowest remaining operand group; operands
   // are kept right-aligned so the group is always bits [BLOCK-1:0].
   for (genvar k = 0; k < NG; k++) begin : g_st
      localparam int IW = WIDTH - k * BLOCK;
      localparam int SW = (k + 1) * BLOCK;

      logic [IW-1:0]    w_a;
      logic [IW-1:0]    w_b;
      logic             w_ci;
      logic             w_vi;
      logic [BLOCK-1:0] w_s;
      logic             w_co;
      logic             w_cm;
      logic [SW-1:0]    w_s_nx;

      logic             r_v;
      logic [SW-1:0]    r_s;

      if (k == 0) begin : g_head
         assign w_a    = a;
         assign w_b    = w_b_eff;
         assign w_ci   = w_c0;
         assign w_vi   = in_valid;
         assign w_s_nx = w_s;
      end else begin : g_body
         assign w_a    = g_st[k-1].g_mid.r_a;
         assign w_b    = g_st[k-1].g_mid.r_b;
         assign w_ci   = g_st[k-1].g_mid.r_c;
         assign w_vi   = g_st[k-1].r_v;
         assign w_s_nx = {w_s, g_st[k-1].r_s};
      end

      cla_group #(.BLOCK(BLOCK)) u_grp (
         .a     (w_a[BLOCK-1:0]),
         .b     (w_b[BLOCK-1:0]),
         .ci    (w_ci),
         .s     (w_s),
         .co    (w_co),
         .c_msb (w_cm)
      );

      // Valid bit and resolved low sum bits advance together
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_v <= 1'b0;
            r_s <= '0;
         end else if (w_adv) begin
            r_v <= w_vi;
            r_s <= w_s_nx;
         end
      end

      if (k < NG - 1) begin : g_mid
         logic [IW-BLOCK-1:0] r_a;
         logic [IW-BLOCK-1:0] r_b;
         logic                r_c;
         logic                w_unused_cm;

         assign w_unused_cm = w_cm;

         // Skew unresolved operand bits and the group carry forward
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
               r_c <= 1'b0;
            end else if (w_adv) begin
               r_a <= w_a[IW-1:BLOCK];
               r_b <= w_b[IW-1:BLOCK];
               r_c <= w_co;
            end
         end
      end else begin : g_tail
         beat_flags_t r_flags;

         // Final group yields raw carry and signed overflow
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_flags <= '0;
            end else if (w_adv) begin
               r_flags <= '{cout: w_co, ovf: w_co ^ w_cm};
            end
         end
      end
   end

   assign out_valid = g_st[NG-1].r_v;
   assign sum       = g_st[NG-1].r_s;
   assign cout      = g_st[NG-1].g_tail.r_flags.cout;
   assign ovf       = g_st[NG-1].g_tail.r_flags.ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random checks of pipelined_cla_adder against
// an arithmetic reference model with an in-order scoreboard.
module tb_pipelined_cla_adder;

   localparam int W  = 16;
   localparam int B  = 4;
   localparam int NG = W / B;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;

   pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Plain integer arithmetic: unsigned sum for carry, signed for overflow
   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tc, input logic ts);
      exp_t        m;
      logic [W:0]  u;
      int          sa;
      int          sb;
      int          r;
      sa = int'($signed(ta));
      sb = int'($signed(tb));
      if (!ts) begin
         u = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
         r = sa + sb + int'(tc);
      end else begin
         u = {1'b0, ta} + {1'b0, ~tb} + {{W{1'b0}}, ~tc};
         r = sa - sb - int'(tc);
      end
      m.s = u[W-1:0];
      m.c = u[W];
      m.o = (r > 32767) || (r < -32768);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
      in_valid = v;
      a        = ta;
      b        = tb;
      cin      = tc;
      sub      = ts;
   endtask

   task automatic drive_rand();
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // Score handshakes seen just before the edge, then take the edge
   task automatic step();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         chk("spurious_out", 32'(q.size() > 0), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
            chk("ovf", ovf, e.o);
         end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (NG + 2) step();
      chk("drained", q.size(), 0);
   endtask

   task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic ts,
                           input logic [W-1:0] es, input logic ec, input logic eo);
      out_ready = 1'b1;
      drive(1'b1, ta, tb, tc, ts);
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= NG; i++) begin
         chk({tag, "_latency"}, out_valid, 32'(i == NG));
         if (i < NG) step();
      end
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, eo);
      step();
      chk({tag, "_idle"}, out_valid, 0);
      chk({tag, "_empty"}, q.size(), 0);
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      directed("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      directed("sub_b0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed("sub_b1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);

      out_ready = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         if (e <= 8) drive_rand();
         else in_valid = 1'b0;
         #1;
         if (e <= 8) chk("stream_in_ready", in_ready, 1);
         step();
         chk("stream_out_valid", out_valid, 32'(e >= NG && e <= NG + 7));
      end
      chk("stream_empty", q.size(), 0);

      out_ready = 1'b1;
      for (int i = 0; i < NG; i++) begin
         drive_rand();
         step();
      end
      out_ready = 1'b0;
      drive_rand();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_in_ready", in_ready, 0);
         step();
         chk("bp_out_valid", out_valid, 1);
         chk("bp_sum", sum, q[0].s);
         chk("bp_cout", cout, q[0].c);
         chk("bp_ovf", ovf, q[0].o);
      end
      chk("bp_pending", q.size(), NG);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) drive_rand();
         #1;
         chk("bp_accept_emit", in_ready, 1);
         step();
      end
      drain();

      out_ready = 1'b1;
      drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      step();
      drive_rand();
      step();
      drive_rand();
      step();
      in_valid = 1'b0;
      step();
      chk("pre_rst_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      q.delete();
      @(posedge clk);
      #3;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_quiet", out_valid, 0);
      end
      directed("post_rst", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
